// File: rtl/pwm_measure.sv
// PWM period and high-time meter: 2-flop synchronizer, optional glitch filter
// (enabled by defining PWM_MEASURE_FILTER_EN), edge detector, IDLE/HIGH/LOW FSM and no-edge timeout.
module pwm_measure #(
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        timeout,
  output logic        level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

  if (TIMEOUT < 2 || FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_param_check
    $error("pwm_measure: TIMEOUT must be >= 2 and FILTER_LEN must be 1..255");
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic sync_q1;
  logic sync_q2;

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

  logic level_q;

`ifdef PWM_MEASURE_FILTER_EN
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic [7:0] filt_cnt;

  // level only follows the synchronizer after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= 1'b0;
      filt_cnt <= '0;
    end else if (sync_q2 == level_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      level_q  <= sync_q2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end
`else
  assign level_q = sync_q2;
`endif

  assign level = level_q;

  logic level_d1;
  logic rise;
  logic fall;
  logic any_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d1 <= 1'b0;
    else     level_d1 <= level_q;
  end

  assign rise     = level_q & ~level_d1;
  assign fall     = ~level_q & level_d1;
  assign any_edge = rise | fall;

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      next_state;
  logic [31:0] period_cnt;
  logic [31:0] high_cnt;
  logic [31:0] idle_cnt;

  logic timeout_hit;
  logic cnt_start;
  logic inc_period;
  logic inc_high;
  logic load_meas;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (!enable || timeout_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) next_state = HIGH;
        HIGH:    if (fall) next_state = LOW;
        LOW:     if (rise) next_state = HIGH;
        default: next_state = IDLE;
      endcase
    end
  end

  // A pending edge always beats the timeout, and a block already timed out
  // stays quiet until a full period is measured again.
  always_comb begin
    timeout_hit = enable && !any_edge && !timeout && (idle_cnt == IDLE_LAST);
    cnt_start   = 1'b0;
    inc_period  = 1'b0;
    inc_high    = 1'b0;
    load_meas   = 1'b0;
    if (enable && !timeout_hit) begin
      case (state)
        IDLE: cnt_start = rise;
        HIGH: begin
          inc_period = 1'b1;
          inc_high   = !fall;
        end
        LOW: begin
          if (rise) begin
            load_meas = 1'b1;
            cnt_start = 1'b1;
          end else begin
            inc_period = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (!enable || timeout_hit) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_start) begin
      period_cnt <= 32'd1;
      high_cnt   <= 32'd1;
    end else begin
      if (inc_period) period_cnt <= sat_inc(period_cnt);
      if (inc_high)   high_cnt   <= sat_inc(high_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!enable || any_edge) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= sat_inc(idle_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= load_meas | timeout_hit;
      if (load_meas) begin
        period    <= period_cnt;
        high_time <= high_cnt;
        timeout   <= 1'b0;
      end else if (timeout_hit) begin
        period    <= '0;
        high_time <= '0;
        timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pwm_measure.md
PWM_MEASURE -- requirements
Module: pwm_measure

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, meaning clk cycles without a detected edge before timeout (2..2^32-1).
REQ-002 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples required by the glitch filter (1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: measurement enable; 0 holds the block in IDLE.
REQ-006 SHALL have port pwm_in, input, 1 bit: asynchronous PWM signal under measurement.
REQ-007 SHALL have port period, output, 32 bits: last measured period in clk cycles.
REQ-008 SHALL have port high_time, output, 32 bits: last measured high time in clk cycles.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle strobe when period/high_time/timeout update.
REQ-010 SHALL have port timeout, output, 1 bit: no edge seen for TIMEOUT cycles; level, not strobe.
REQ-011 SHALL have port level, output, 1 bit: filtered, synchronized pwm_in.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer, then through the edge detector; rise = level & ~level_d1, fall = ~level & level_d1.
REQ-013 SHALL run the FSM with states IDLE, HIGH, LOW.
REQ-014 IDLE: counters held at 0; on rise -> HIGH, period_cnt <= 1, high_cnt <= 1, no valid (incomplete period).
REQ-015 HIGH: period_cnt and high_cnt increment each cycle; on fall -> LOW, high_cnt frozen.
REQ-016 LOW: period_cnt increments each cycle; on rise -> HIGH, with period <= period_cnt, high_time <= high_cnt, valid = 1 for that cycle, timeout <= 0, period_cnt <= 1, high_cnt <= 1.
REQ-017 For an input of period P and high width H cycles (both >= 2), period SHALL equal P and high_time SHALL equal H.
REQ-018 valid SHALL assert 3 clk cycles after the pwm_in rising transition (2 sync + 1 edge stage), without the filter.
REQ-019 An idle counter SHALL reset on every rise or fall and increment otherwise; when it reaches TIMEOUT in any state, the block SHALL set period = 0, high_time = 0 and timeout = 1, pulse valid once, and go to IDLE.
REQ-020 While timed out, the block SHALL issue no further valid until the next complete period; level SHALL still distinguish stuck-high from stuck-low.
REQ-021 Counters SHALL saturate at 2^32-1 and never wrap.
REQ-022 A rise and a timeout in the same cycle SHALL resolve in favor of the rise; timeout is not asserted.
REQ-023 enable = 0 SHALL force IDLE and clear the counters, hold period/high_time/timeout, and issue no valid.
REQ-024 After enable rises, the first valid SHALL follow the second detected rise.

Reset
REQ-025 rst = 1 SHALL immediately set state = IDLE, every counter = 0, the synchronizer and filter flops = 0, period = 0, high_time = 0, valid = 0, timeout = 0 and level = 0.
REQ-026 A reset mid-period SHALL discard the partial measurement; the first valid after release SHALL follow two rises.

Configuration
REQ-027 Macro PWM_MEASURE_FILTER_EN defined: level SHALL change only after FILTER_LEN consecutive equal synchronized samples, which adds FILTER_LEN cycles of latency; shorter glitches SHALL be ignored.
REQ-028 Macro PWM_MEASURE_FILTER_EN undefined: level SHALL equal the synchronizer output, FILTER_LEN is unused and latency follows REQ-018.

Verification
REQ-029 Without the filter, input period 100 and high 25, enable = 1 -> from the second rise, valid every 100 cycles with period = 100, high_time = 25, timeout = 0.
REQ-030 Change to period 40, high 30 mid-run -> the first full new period reports 40/30; there is at most one transitional sample.
REQ-031 TIMEOUT = 500, input held low after one period -> valid with period = 0, high_time = 0, timeout = 1 exactly 500 cycles after the last edge; level = 0.
REQ-032 PWM_MEASURE_FILTER_EN with FILTER_LEN = 4, a 2-cycle high glitch inside the low phase -> no change in level, and the period is still reported as 100.
REQ-033 rst pulsed at cycle 50 of a 100-cycle period -> all outputs 0 immediately, and the first valid comes at the second rise after release with period = 100.
REQ-034 enable dropped for 300 cycles, then raised -> no valid while low, outputs held, and correct 100/25 results after two rises.
